// File: rtl/fifo_wptr_full.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wptr_full
// Purpose  : Write-side pointer, read-pointer synchroniser and full/level
//            status for a dual-clock FIFO (write clock domain only).
// Revision : 1.0
// ============================================================================
module fifo_wptr_full #(
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6
) (
  input  logic                  wclk,
  input  logic                  rst_n,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   rptr_gray,
  input  logic                  ovf_clr,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  woverflow
);

  localparam int              c_PW        = ADDR_WIDTH + 1;
  localparam logic [c_PW-1:0] c_FULL_MASK = {2'b11, {(ADDR_WIDTH-1){1'b0}}};
  localparam logic [c_PW-1:0] c_AF_LEVEL  = c_PW'(AF_LEVEL);

  logic [c_PW-1:0] wbin_q, wbin_d;
  logic [c_PW-1:0] wgray_q, wgray_d;
  logic [c_PW-1:0] rq1_q, rq2_q;
  logic            wfull_q, wfull_d;
  logic            wovf_q, wovf_d;
  logic [c_PW-1:0] w_rbin;

  assign wen = winc & ~wfull_q;

  always_comb begin
    wbin_d  = wbin_q + c_PW'(wen);
    wgray_d = wbin_d ^ (wbin_d >> 1);
    // Full when the next write pointer has lapped the read pointer: Gray
    // pointers then differ only in their two top bits.
    wfull_d = (wgray_d == (rq2_q ^ c_FULL_MASK));
    wovf_d  = wovf_q;
    if (ovf_clr)
      wovf_d = 1'b0;
    if (winc && wfull_q)
      wovf_d = 1'b1;
  end

  always_comb begin
    w_rbin = '0;
    w_rbin[c_PW-1] = rq2_q[c_PW-1];
    for (int i = c_PW - 2; i >= 0; i--)
      w_rbin[i] = w_rbin[i+1] ^ rq2_q[i];
  end

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      rq1_q   <= '0;
      rq2_q   <= '0;
      wfull_q <= 1'b0;
      wovf_q  <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      rq1_q   <= rptr_gray;
      rq2_q   <= rq1_q;
      wfull_q <= wfull_d;
      wovf_q  <= wovf_d;
    end
  end

  assign waddr        = wbin_q[ADDR_WIDTH-1:0];
  assign wptr_gray    = wgray_q;
  assign wfull        = wfull_q;
  assign woverflow    = wovf_q;
  assign wlevel       = wbin_q - w_rbin;
  assign walmost_full = (wlevel >= c_AF_LEVEL);

endmodule
`default_nettype wire
